// File: rtl/ptw_mem_port_pkg.sv
// Shared types for the page-table walker PTE read port: walker FSM states,
// data-bus request/response records, access sizes and PTE field positions.
package ptw_mem_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  // PTE field positions (Sv39/Sv48 layout)
  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_PPN_LSB = 10;
  localparam int PTE_PPN_MSB = 53;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ptw_pte_cache.sv
// Direct-mapped PTE cache: DEPTH entries of {valid, tag, data}.
// Combinational lookup port, single fill port, whole-array flush.
module ptw_pte_cache #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int TAG_W = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [IDX_W-1:0] lk_index,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_hit,
  output logic [63:0]      lk_data,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [63:0]      fill_data
);

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [DEPTH];
  logic [63:0]      data_mem [DEPTH];

  // Valid bits: cleared by reset or flush, set by a fill; flush wins over fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; an entry is only trusted once valid.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= fill_data;
    end
  end

  assign lk_data = data_mem[lk_index];
  assign lk_hit  = valid_q[lk_index] && (tag_mem[lk_index] == lk_tag);

endmodule

// File: rtl/ptw_mem_port.sv
// Memory-side responder for the walker's PTE read port. Serves one 8-byte
// PTE read at a time from the PTE cache, or fetches it over the data bus,
// and returns it with a one-cycle valid pulse.
module ptw_mem_port
  import ptw_mem_port_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 56
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        mem_req,
  input  logic [63:0] mem_addr,
  output logic [63:0] mem_data,
  output logic        mem_data_valid,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LA_W  = ADDR_W - 3;      // 8-byte line address width
  localparam int TAG_W = LA_W - IDX_W;

  state_t            state_q, state_d;
  logic [LA_W-1:0]   addr_q, addr_d;
  logic              abort_q, abort_d;
  logic              fill_kill_q, fill_kill_d;
  logic [63:0]       mem_data_q, mem_data_d;
  logic              valid_q, valid_d;
  logic [31:0]       hits_q, hits_d;
  logic [31:0]       misses_q, misses_d;

  logic [LA_W-1:0]   req_line;
  logic              req_lost;
  logic              take_resp;
  logic              fill_en;
  logic              lk_hit;
  logic [63:0]       lk_data;
  dbus_req_t         dreq;

  // Address bits outside the significant PTE line address are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[63:ADDR_W], mem_addr[2:0]};

  assign req_line = mem_addr[ADDR_W-1:3];
  // Walker withdrew or changed its request since it was latched.
  assign req_lost = !mem_req || (req_line != addr_q);

  ptw_pte_cache #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_cache (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .lk_index   (addr_q[IDX_W-1:0]),
    .lk_tag     (addr_q[LA_W-1:IDX_W]),
    .lk_hit     (lk_hit),
    .lk_data    (lk_data),
    .fill_en    (fill_en),
    .fill_index (addr_q[IDX_W-1:0]),
    .fill_tag   (addr_q[LA_W-1:IDX_W]),
    .fill_data  (dresp_data)
  );

  // Next-state, datapath and counter updates for the request FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    abort_d     = abort_q;
    fill_kill_d = fill_kill_q;
    mem_data_d  = mem_data_q;
    valid_d     = 1'b0;
    hits_d      = hits_q;
    misses_d    = misses_q;
    take_resp   = 1'b0;
    fill_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        abort_d     = 1'b0;
        fill_kill_d = 1'b0;
        // Not while a hit pulse is still out: the walker has yet to see it.
        if (mem_req && !valid_q) begin
          addr_d  = req_line;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (req_lost) begin
          state_d = ST_IDLE;
        end else if (lk_hit) begin
          mem_data_d = lk_data;
          valid_d    = 1'b1;
          hits_d     = sat_inc(hits_q);
          state_d    = ST_IDLE;
        end else begin
          misses_d = sat_inc(misses_q);
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        abort_d = abort_q | req_lost;
        if (flush) fill_kill_d = 1'b1;
        if (dresp_addr_ok) begin
          if (dresp_data_ok) take_resp = 1'b1;
          else               state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        abort_d = abort_q | req_lost;
        if (flush) fill_kill_d = 1'b1;
        if (dresp_data_ok) take_resp = 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bus data arrived: fill unless a flush raced it, answer unless aborted.
    if (take_resp) begin
      fill_en = !(fill_kill_q || flush);
      if (abort_q || req_lost) begin
        state_d = ST_IDLE;
      end else begin
        mem_data_d = dresp_data;
        valid_d    = 1'b1;
        state_d    = ST_RESP;
      end
    end
  end

  // State, latched request and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      abort_q     <= 1'b0;
      fill_kill_q <= 1'b0;
      mem_data_q  <= '0;
      valid_q     <= 1'b0;
      hits_q      <= '0;
      misses_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      abort_q     <= abort_d;
      fill_kill_q <= fill_kill_d;
      mem_data_q  <= mem_data_d;
      valid_q     <= valid_d;
      hits_q      <= hits_d;
      misses_q    <= misses_d;
    end
  end

  // Bus request fields are driven straight from state so they hold until addr_ok.
  always_comb begin
    dreq.valid  = (state_q == ST_REQ);
    dreq.addr   = 64'({addr_q, 3'b000});
    dreq.size   = MSIZE8;
    dreq.strobe = 8'h00;
  end

  assign dreq_valid     = dreq.valid;
  assign dreq_addr      = dreq.addr;
  assign dreq_size      = dreq.size;
  assign dreq_strobe    = dreq.strobe;
  assign mem_data       = mem_data_q;
  assign mem_data_valid = valid_q;
  assign perf_hits      = hits_q;
  assign perf_misses    = misses_q;

endmodule

// File: tb/tb_ptw_mem_port.sv
// Self-checking bench for ptw_mem_port: scoreboard of expected PTEs checked
// on every mem_data_valid pulse, plus timing and counter checks per scenario.
module tb_ptw_mem_port;
  import ptw_mem_port_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        mem_req = 1'b0;
  logic [63:0] mem_addr = '0;
  logic [63:0] mem_data;
  logic        mem_data_valid;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_addr_ok = 1'b0;
  logic        dresp_data_ok = 1'b0;
  logic [63:0] dresp_data = '0;
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] sb_q[$];
  logic [63:0] sb_exp;

  localparam logic [63:0] A1 = 64'h8000_1000;
  localparam logic [63:0] A1C = 64'h8000_1040;
  localparam logic [63:0] A2 = 64'h8000_2008;
  localparam logic [63:0] A3 = 64'h8000_3010;
  localparam logic [63:0] A4 = 64'h8000_4018;
  localparam logic [63:0] P1 = 64'h2000_0401;
  localparam logic [63:0] P1C = 64'h2000_08CF;
  localparam logic [63:0] P2 = 64'h2000_0C0B;
  localparam logic [63:0] P3 = 64'h2000_1007;
  localparam logic [63:0] P4 = 64'h2000_1401;

  always #5 clk = ~clk;

  ptw_mem_port #(.DEPTH(8), .ADDR_W(56)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_data_valid (mem_data_valid),
    .dreq_valid     (dreq_valid),
    .dreq_addr      (dreq_addr),
    .dreq_size      (dreq_size),
    .dreq_strobe    (dreq_strobe),
    .dresp_addr_ok  (dresp_addr_ok),
    .dresp_data_ok  (dresp_data_ok),
    .dresp_data     (dresp_data),
    .perf_hits      (perf_hits),
    .perf_misses    (perf_misses)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h, want 0x%016h", tag, obs, exp);
  endtask

  // Scoreboard: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && mem_data_valid) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_pulse", 64'(mem_data_valid), 64'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        check_val("sb_data", mem_data, sb_exp);
        $display("pulse  data=0x%016h exp=0x%016h", mem_data, sb_exp);
      end
    end
  end

  task automatic check_perf(input logic [31:0] h, input logic [31:0] m);
    check_val("perf_hits", 64'(perf_hits), 64'(h));
    check_val("perf_misses", 64'(perf_misses), 64'(m));
  endtask

  task automatic wait_dreq(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dreq_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_val(tag, 64'(seen), 64'd1);
  endtask

  task automatic miss_read(input logic [63:0] addr, input logic [63:0] pte,
                           input int aok_dly, input bit zero_lat, input bit flush_wait);
    $display("miss   addr=0x%016h pte=0x%016h aok_dly=%0d zl=%0d fw=%0d",
             addr, pte, aok_dly, zero_lat, flush_wait);
    sb_q.push_back(pte);
    @(negedge clk);
    mem_req = 1'b1;
    mem_addr = addr;
    wait_dreq("miss_dreq");
    check_val("dreq_addr", dreq_addr, addr);
    check_val("dreq_size", 64'(dreq_size), 64'(MSIZE8));
    check_val("dreq_strobe", 64'(dreq_strobe), 64'd0);
    repeat (aok_dly) begin
      @(negedge clk);
      check_val("dreq_hold", 64'(dreq_valid), 64'd1);
    end
    dresp_addr_ok = 1'b1;
    dresp_data = pte;
    dresp_data_ok = zero_lat;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    if (!zero_lat) begin
      check_val("dreq_drop", 64'(dreq_valid), 64'd0);
      check_val("wait_no_pulse", 64'(mem_data_valid), 64'd0);
      if (flush_wait) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
      dresp_data_ok = 1'b1;
      @(negedge clk);
      dresp_data_ok = 1'b0;
    end
    check_val("miss_pulse", 64'(mem_data_valid), 64'd1);
    mem_req = 1'b0;
    dresp_data = 64'hDEAD_BEEF_0000_0000;
    @(negedge clk);
    check_val("single_pulse", 64'(mem_data_valid), 64'd0);
  endtask

  task automatic hit_read(input logic [63:0] addr, input logic [63:0] pte, input bit flush_chk);
    $display("hit    addr=0x%016h pte=0x%016h flush_in_check=%0d", addr, pte, flush_chk);
    sb_q.push_back(pte);
    @(negedge clk);
    mem_req = 1'b1;
    mem_addr = addr;
    @(negedge clk);
    check_val("hit_early", 64'(mem_data_valid), 64'd0);
    if (flush_chk) flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_val("hit_pulse", 64'(mem_data_valid), 64'd1);
    check_val("hit_no_dreq", 64'(dreq_valid), 64'd0);
    mem_req = 1'b0;
    @(negedge clk);
    check_val("single_pulse", 64'(mem_data_valid), 64'd0);
    check_val("hit_no_dreq2", 64'(dreq_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_mem_data", mem_data, 64'd0);
    check_val("rst_valid", 64'(mem_data_valid), 64'd0);
    check_val("rst_dreq", 64'(dreq_valid), 64'd0);
    check_perf(32'd0, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Cold miss, then hit on the same PTE
    miss_read(A1, P1, 1, 1'b0, 1'b0);
    check_perf(32'd0, 32'd1);
    hit_read(A1, P1, 1'b0);
    check_perf(32'd1, 32'd1);

    // Same-index conflict evicts
    miss_read(A1C, P1C, 0, 1'b1, 1'b0);
    miss_read(A1, P1, 2, 1'b0, 1'b0);
    check_perf(32'd1, 32'd3);

    // Abort while waiting on addr_ok: request held, no pulse, fill kept
    $display("abort  addr=0x%016h", A2);
    @(negedge clk);
    mem_req = 1'b1;
    mem_addr = A2;
    wait_dreq("abort_dreq");
    mem_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("abort_hold", 64'(dreq_valid), 64'd1);
    end
    dresp_addr_ok = 1'b1;
    dresp_data = P2;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b1;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_val("abort_no_pulse", 64'(mem_data_valid), 64'd0);
    end
    check_perf(32'd1, 32'd4);
    hit_read(A2, P2, 1'b0);
    check_perf(32'd2, 32'd4);

    // Flush during WAIT: answer delivered, fill dropped
    miss_read(A3, P3, 0, 1'b0, 1'b1);
    miss_read(A3, P3, 0, 1'b0, 1'b0);
    hit_read(A3, P3, 1'b0);
    check_perf(32'd3, 32'd6);

    // Flush in the same cycle as a hit: hit served, array cleared
    hit_read(A3, P3, 1'b1);
    miss_read(A3, P3, 0, 1'b0, 1'b0);
    miss_read(A1, P1, 0, 1'b0, 1'b0);
    hit_read(A1, P1, 1'b0);
    check_perf(32'd5, 32'd8);

    // Asynchronous reset during WAIT
    $display("reset  during WAIT addr=0x%016h", A4);
    @(negedge clk);
    mem_req = 1'b1;
    mem_addr = A4;
    wait_dreq("rst_wait_dreq");
    dresp_addr_ok = 1'b1;
    dresp_data = P4;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_val("arst_mem_data", mem_data, 64'd0);
    check_val("arst_valid", 64'(mem_data_valid), 64'd0);
    check_val("arst_dreq", 64'(dreq_valid), 64'd0);
    check_perf(32'd0, 32'd0);
    mem_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    miss_read(A1, P1, 0, 1'b0, 1'b0);
    check_perf(32'd0, 32'd1);
    check_val("sb_drained", 64'(sb_q.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
